usb_flash_arb: RTL and testbench



---
 rtl/usb_flash_arb.sv | 130 +++++++++++++
 tb/tb_usb_flash_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_flash_arb.sv
// usb_flash_arb: hands the single SPI flash port to one of two requesters for a
// whole transaction at a time. It registers the owner's SPI signals onto the
// flash pins and enforces a chip-select idle gap between owners. A watchdog
// revokes ownership from a requester that holds the bus for too long.
module usb_flash_arb #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 48000000,
  parameter int PRIO_USB       = 1
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic req0,
  output logic grant0,
  input  logic spi_csel0,
  input  logic spi_clk0,
  input  logic spi_mosi0,
  output logic spi_miso0,
  input  logic req1,
  output logic grant1,
  input  logic spi_csel1,
  input  logic spi_clk1,
  input  logic spi_mosi1,
  output logic spi_miso1,
  output logic spi_csel,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic timeout_err
);

  // state | meaning
  // IDLE  | no owner, arbitrating eligible requests
  // OWN0  | requester 0 (USB DFU) owns the flash pins
  // OWN1  | requester 1 (local logic) owns the flash pins
  // GAP   | pins held idle between owners
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  // GAP_CYCLES of 0 or 1 both give a single-cycle gap.
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          lockout0, lockout1;
  logic          last_owner;
  logic          elig0, elig1;
  logic          release_now, revoke_now;
  logic          gap_done;
  logic [2:0]    pins_nxt;

  assign gap_done = (gap_cnt == GAP_LAST);

  // Arbitration, release/watchdog decisions and the next value of the pins.
  always_comb begin
    state_nxt   = state;
    release_now = 1'b0;
    revoke_now  = 1'b0;
    pins_nxt    = 3'b100;
    elig0       = req0 & ~lockout0;
    elig1       = req1 & ~lockout1;
    case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          if (PRIO_USB != 0) state_nxt = OWN0;
          else               state_nxt = last_owner ? OWN0 : OWN1;
        end else if (elig0) begin
          state_nxt = OWN0;
        end else if (elig1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        // A release on the watchdog's last cycle wins over the revoke.
        if (!req0)                  release_now = 1'b1;
        else if (to_cnt == TO_LAST) revoke_now  = 1'b1;
        else                        pins_nxt    = {spi_csel0, spi_clk0, spi_mosi0};
        if (release_now || revoke_now) state_nxt = GAP;
      end
      OWN1: begin
        if (!req1)                  release_now = 1'b1;
        else if (to_cnt == TO_LAST) revoke_now  = 1'b1;
        else                        pins_nxt    = {spi_csel1, spi_clk1, spi_mosi1};
        if (release_now || revoke_now) state_nxt = GAP;
      end
      GAP: begin
        if (gap_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, lockouts and registered flash pins.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      lockout0    <= 1'b0;
      lockout1    <= 1'b0;
      last_owner  <= 1'b1;
      timeout_err <= 1'b0;
      spi_csel    <= 1'b1;
      spi_clk     <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= ((state == OWN0 || state == OWN1) && state_nxt == state) ? to_cnt + 1'b1 : '0;
      gap_cnt     <= (state == GAP && !gap_done) ? gap_cnt + 1'b1 : '0;
      lockout0    <= (revoke_now && state == OWN0) | (lockout0 & req0);
      lockout1    <= (revoke_now && state == OWN1) | (lockout1 & req1);
      timeout_err <= revoke_now;
      if (release_now || revoke_now) last_owner <= (state == OWN1);
      {spi_csel, spi_clk, spi_mosi} <= pins_nxt;
    end
  end

  // Ownership flags and MISO return path; the non-owner sees 0.
  always_comb begin
    grant0    = (state == OWN0);
    grant1    = (state == OWN1);
    busy      = (state != IDLE);
    spi_miso0 = grant0 & spi_miso;
    spi_miso1 = grant1 & spi_miso;
  end

endmodule

// File: tb/tb_usb_flash_arb.sv
// Testbench for usb_flash_arb: directed vector table, multi-cycle corner
// sequences, and a randomized run compared against a behavioural model.
// Instance a: GAP=4, TIMEOUT=16, USB priority. Instance b: GAP=0, TIMEOUT=16, round-robin.
module tb_usb_flash_arb;

  localparam int TO = 16;

  logic clk_48mhz = 1'b0;
  always #5 clk_48mhz = ~clk_48mhz;

  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic spi_csel0 = 1'b1, spi_clk0 = 1'b0, spi_mosi0 = 1'b0;
  logic spi_csel1 = 1'b1, spi_clk1 = 1'b0, spi_mosi1 = 1'b0;
  logic spi_miso = 1'b0;

  logic a_grant0, a_grant1, a_spi_miso0, a_spi_miso1, a_spi_csel, a_spi_clk, a_spi_mosi, a_busy, a_timeout_err;
  logic b_grant0, b_grant1, b_spi_miso0, b_spi_miso1, b_spi_csel, b_spi_clk, b_spi_mosi, b_busy, b_timeout_err;
  logic [8:0] out_a, out_b;

  assign out_a = {a_grant0, a_grant1, a_spi_csel, a_spi_clk, a_spi_mosi, a_spi_miso0, a_spi_miso1, a_busy, a_timeout_err};
  assign out_b = {b_grant0, b_grant1, b_spi_csel, b_spi_clk, b_spi_mosi, b_spi_miso0, b_spi_miso1, b_busy, b_timeout_err};

  usb_flash_arb #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(TO), .PRIO_USB(1)) dut_a (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .req0(req0), .grant0(a_grant0), .spi_csel0(spi_csel0), .spi_clk0(spi_clk0), .spi_mosi0(spi_mosi0), .spi_miso0(a_spi_miso0),
    .req1(req1), .grant1(a_grant1), .spi_csel1(spi_csel1), .spi_clk1(spi_clk1), .spi_mosi1(spi_mosi1), .spi_miso1(a_spi_miso1),
    .spi_csel(a_spi_csel), .spi_clk(a_spi_clk), .spi_mosi(a_spi_mosi), .spi_miso(spi_miso),
    .busy(a_busy), .timeout_err(a_timeout_err));

  usb_flash_arb #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO), .PRIO_USB(0)) dut_b (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .req0(req0), .grant0(b_grant0), .spi_csel0(spi_csel0), .spi_clk0(spi_clk0), .spi_mosi0(spi_mosi0), .spi_miso0(b_spi_miso0),
    .req1(req1), .grant1(b_grant1), .spi_csel1(spi_csel1), .spi_clk1(spi_clk1), .spi_mosi1(spi_mosi1), .spi_miso1(b_spi_miso1),
    .spi_csel(b_spi_csel), .spi_clk(b_spi_clk), .spi_mosi(b_spi_mosi), .spi_miso(spi_miso),
    .busy(b_busy), .timeout_err(b_timeout_err));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody), remaining gap cycles,
  // cycles held, last owner, lockouts, registered pin values, error pulse.
  int       cfg_gap [2] = '{4, 0};
  int       cfg_prio[2] = '{1, 0};
  int       m_owner[2], m_gap[2], m_held[2], m_last[2];
  bit       m_lock [2][2];
  bit [2:0] m_pins [2];
  bit       m_terr [2];

  task automatic model_step(input int k);
    bit       rq[2];
    bit [2:0] pin_in[2];
    bit       nl[2];
    bit [2:0] np;
    bit       e0, e1;
    int       n, g;
    rq[0] = req0; rq[1] = req1;
    pin_in[0] = {spi_csel0, spi_clk0, spi_mosi0};
    pin_in[1] = {spi_csel1, spi_clk1, spi_mosi1};
    g = (cfg_gap[k] > 1) ? cfg_gap[k] : 1;
    if (reset) begin
      m_owner[k] = -1; m_gap[k] = 0; m_held[k] = 0; m_last[k] = 1;
      m_lock[k][0] = 0; m_lock[k][1] = 0; m_pins[k] = 3'b100; m_terr[k] = 0;
      return;
    end
    np = 3'b100;
    m_terr[k] = 0;
    for (int i = 0; i < 2; i++) nl[i] = m_lock[k][i] && rq[i];
    if (m_owner[k] >= 0) begin
      n = m_owner[k];
      if (!rq[n]) begin
        m_last[k] = n; m_owner[k] = -1; m_gap[k] = g;
      end else if (m_held[k] == TO - 1) begin
        m_last[k] = n; m_owner[k] = -1; m_gap[k] = g; m_terr[k] = 1; nl[n] = 1;
      end else begin
        m_held[k]++;
        np = pin_in[n];
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else begin
      e0 = rq[0] && !m_lock[k][0];
      e1 = rq[1] && !m_lock[k][1];
      if (e0 && e1) m_owner[k] = (cfg_prio[k] != 0) ? 0 : 1 - m_last[k];
      else if (e0)  m_owner[k] = 0;
      else if (e1)  m_owner[k] = 1;
      m_held[k] = 0;
    end
    m_lock[k][0] = nl[0];
    m_lock[k][1] = nl[1];
    m_pins[k] = np;
  endtask

  function automatic logic [8:0] model_out(input int k);
    logic o0, o1, bz;
    o0 = (m_owner[k] == 0);
    o1 = (m_owner[k] == 1);
    bz = (m_owner[k] >= 0) || (m_gap[k] > 0);
    return {o0, o1, m_pins[k], o0 & spi_miso, o1 & spi_miso, bz, m_terr[k]};
  endfunction

  task automatic tick();
    @(posedge clk_48mhz);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((a_busy || b_busy) && n < 40) begin
      tick();
      n++;
    end
    check(name, {31'b0, a_busy | b_busy}, 32'd0);
  endtask

  typedef struct {
    logic       rst, r0, r1;
    logic [2:0] p0, p1;
    logic       miso;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic r0, input logic r1, input logic [2:0] p0,
                     input logic [2:0] p1, input logic miso, input logic [8:0] exp);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.p0 = p0; v.p1 = p1; v.miso = miso; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    int ga, gb, n;
    bit da, db, seen;
    bit exp_b1[3];

    // Output order: grant0 grant1 | csel clk mosi | miso0 miso1 | busy terr (instance a)
    add(1, 0, 0, 3'b100, 3'b100, 0, 9'b001000000);
    add(0, 1, 0, 3'b100, 3'b100, 0, 9'b101000010);
    add(0, 1, 0, 3'b001, 3'b100, 1, 9'b100011010);
    add(0, 1, 0, 3'b010, 3'b100, 0, 9'b100100010);
    add(0, 0, 0, 3'b011, 3'b100, 1, 9'b001000010);
    add(0, 0, 0, 3'b000, 3'b100, 1, 9'b001000010);
    add(0, 0, 0, 3'b000, 3'b100, 1, 9'b001000010);
    add(0, 0, 0, 3'b000, 3'b100, 1, 9'b001000010);
    add(0, 0, 0, 3'b000, 3'b100, 1, 9'b001000000);
    add(0, 0, 1, 3'b100, 3'b000, 0, 9'b011000010);
    add(0, 0, 1, 3'b100, 3'b011, 1, 9'b010110110);
    add(0, 1, 1, 3'b100, 3'b000, 0, 9'b010000010);
    add(0, 1, 0, 3'b100, 3'b000, 0, 9'b001000010);
    add(0, 1, 0, 3'b100, 3'b100, 0, 9'b001000010);
    add(0, 1, 0, 3'b100, 3'b100, 0, 9'b001000010);
    add(0, 1, 0, 3'b100, 3'b100, 0, 9'b001000010);
    add(0, 1, 0, 3'b100, 3'b100, 0, 9'b001000000);
    add(0, 1, 0, 3'b100, 3'b100, 0, 9'b101000010);
    add(0, 0, 0, 3'b100, 3'b100, 0, 9'b001000010);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
      {spi_csel0, spi_clk0, spi_mosi0} = vecs[i].p0;
      {spi_csel1, spi_clk1, spi_mosi1} = vecs[i].p1;
      spi_miso = vecs[i].miso;
      tick();
      check($sformatf("vec%0d", i), {23'b0, out_a}, {23'b0, vecs[i].exp});
    end
    spi_csel0 = 1; spi_clk0 = 0; spi_mosi0 = 0; spi_miso = 0;
    wait_idle("vec_idle");

    // Ties: a always picks 0; b alternates starting with 0.
    reset = 1; tick(); reset = 0;
    exp_b1 = '{0, 1, 0};
    for (int r = 0; r < 3; r++) begin
      req0 = 1; req1 = 1;
      tick();
      check($sformatf("tie_a%0d", r), {30'b0, a_grant0, a_grant1}, 32'd2);
      check($sformatf("tie_b%0d", r), {30'b0, b_grant0, b_grant1}, exp_b1[r] ? 32'd1 : 32'd2);
      tick(); tick();
      req0 = 0; req1 = 0;
      tick();
      wait_idle($sformatf("tie_idle%0d", r));
    end

    // Handover 0 -> 1: gap cycles with csel high, 4 on a, 1 on b.
    req0 = 1;
    tick(); tick();
    req0 = 0; req1 = 1;
    ga = 0; gb = 0; da = 0; db = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!da) begin
        if (a_grant1) da = 1;
        else if (a_busy && !a_grant0 && a_spi_csel) ga++;
      end
      if (!db) begin
        if (b_grant1) db = 1;
        else if (b_busy && !b_grant0 && b_spi_csel) gb++;
      end
    end
    check("handover_a_granted", {31'b0, da}, 32'd1);
    check("handover_b_granted", {31'b0, db}, 32'd1);
    check("gap_cycles_a", ga, 32'd4);
    check("gap_cycles_b", gb, 32'd1);
    req1 = 0;
    tick();
    wait_idle("handover_idle");

    // Watchdog on requester 1.
    req1 = 1;
    tick();
    check("wd_grant", {30'b0, a_grant1, b_grant1}, 32'd3);
    n = 0;
    while (a_grant1 && n < 40) begin
      tick();
      n++;
    end
    check("wd_hold_cycles", n, TO);
    check("wd_terr_a", {31'b0, a_timeout_err}, 32'd1);
    check("wd_terr_b", {31'b0, b_timeout_err}, 32'd1);
    check("wd_csel", {30'b0, a_spi_csel, b_spi_csel}, 32'd3);
    check("wd_b_grant", {31'b0, b_grant1}, 32'd0);
    tick();
    check("wd_terr_pulse", {30'b0, a_timeout_err, b_timeout_err}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_grant1 || b_grant1) seen = 1;
    end
    check("wd_lockout", {31'b0, seen}, 32'd0);
    check("wd_lockout_idle", {30'b0, a_busy, b_busy}, 32'd0);
    req1 = 0; tick();
    req1 = 1; tick();
    check("wd_regrant", {30'b0, a_grant1, b_grant1}, 32'd3);
    req1 = 0;
    tick();
    wait_idle("wd_idle");

    // Release on the watchdog's final cycle is a normal release.
    req0 = 1;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    req0 = 0;
    tick();
    check("coin_grant", {30'b0, a_grant0, b_grant0}, 32'd0);
    check("coin_terr", {30'b0, a_timeout_err, b_timeout_err}, 32'd0);
    tick();
    check("coin_terr_next", {30'b0, a_timeout_err, b_timeout_err}, 32'd0);
    wait_idle("coin_idle");
    req0 = 1;
    tick();
    check("coin_regrant", {30'b0, a_grant0, b_grant0}, 32'd3);
    req0 = 0;
    tick();
    wait_idle("coin_idle2");

    // Reset while owner 1 holds csel low.
    req1 = 1;
    tick();
    spi_csel1 = 0;
    tick(); tick();
    check("rst_pre_csel", {30'b0, a_spi_csel, b_spi_csel}, 32'd0);
    reset = 1;
    tick();
    check("rst_a", {29'b0, a_grant1, a_spi_csel, a_busy}, 32'b010);
    check("rst_b", {29'b0, b_grant1, b_spi_csel, b_busy}, 32'b010);
    reset = 0;
    tick();
    check("rst_first_grant", {30'b0, a_grant1, b_grant1}, 32'd3);
    req1 = 0; spi_csel1 = 1;
    tick();
    wait_idle("rst_idle");

    // Randomized run against the model.
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 11) == 0) req0 = ~req0;
      if ($urandom_range(0, 11) == 0) req1 = ~req1;
      {spi_csel0, spi_clk0, spi_mosi0} = 3'($urandom);
      {spi_csel1, spi_clk1, spi_mosi1} = 3'($urandom);
      spi_miso = 1'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      tick();
      check($sformatf("rand_a%0d", c), {23'b0, out_a}, {23'b0, model_out(0)});
      check($sformatf("rand_b%0d", c), {23'b0, out_b}, {23'b0, model_out(1)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
